// File: rtl/clip_sched.sv
// rtl/clip_sched.sv - two-requester Cohen-Sutherland line clipper with a 32-cycle sequential divider
// Define CLIP_SCHED_RR_EN for round-robin arbitration; fixed priority (requester 0 wins) otherwise.
module clip_sched #(
  parameter logic signed [15:0] XMIN = 16'sd0,
  parameter logic signed [15:0] XMAX = 16'sd799,
  parameter logic signed [15:0] YMIN = 16'sd0,
  parameter logic signed [15:0] YMAX = 16'sd479
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req0_valid,
  input  logic        i_req1_valid,
  output logic        o_req0_ready,
  output logic        o_req1_ready,
  input  logic [63:0] i_req0_line,
  input  logic [63:0] i_req1_line,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_line,
  output logic        o_reject,
  output logic        o_id,
  output logic        o_busy
);
  typedef enum logic [2:0] {IDLE, CODE, DIV, UPD, DONE} state_t;
  localparam logic [3:0] MAX_STEPS = 4'd8;

  state_t state, state_nx;
  logic signed [15:0] x1, y1, x2, y2;
  logic               id_q, reject_q;
  logic [3:0]         steps;
  logic [4:0]         div_cnt;
  logic [31:0]        rem, quo, dvs;
  logic               q_neg, tgt_ep2, tgt_x;
  logic signed [15:0] edge_q;

  logic               grant_any, grant_id, accept;
  logic [3:0]         oc1, oc2, oc_t;
  logic               trivial_in, trivial_out, resolve;
  logic               sel_ep2, sel_x;
  logic signed [15:0] edge_v, coord;
  logic signed [31:0] dx, dy, d_edge, d_other, num;
  logic [31:0]        num_mag, den_mag;
  logic [32:0]        rem_sh, rem_diff;
  logic               rem_ge;
  logic [15:0]        quot;

  function automatic logic [3:0] outcode(input logic signed [15:0] x, input logic signed [15:0] y);
    logic [3:0] c;
    c = 4'b0000;
    if (x < XMIN) c[0] = 1'b1;
    if (x > XMAX) c[1] = 1'b1;
    if (y > YMAX) c[2] = 1'b1;
    if (y < YMIN) c[3] = 1'b1;
    return c;
  endfunction

  function automatic logic signed [31:0] sx(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  assign grant_any = i_req0_valid | i_req1_valid;

`ifdef CLIP_SCHED_RR_EN
  logic rr_last;
  // rr_last resets to 1 so the first contested grant goes to requester 0
  assign grant_id = (i_req0_valid & i_req1_valid) ? ~rr_last : ~i_req0_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_last <= 1'b1;
    else if (accept)
      rr_last <= grant_id;
  end
`else
  assign grant_id = ~i_req0_valid;
`endif

  assign accept       = rst_n && (state == IDLE) && grant_any;
  assign o_req0_ready = accept & ~grant_id;
  assign o_req1_ready = accept & grant_id;

  always_comb begin
    oc1         = outcode(x1, y1);
    oc2         = outcode(x2, y2);
    trivial_in  = (oc1 | oc2) == 4'b0000;
    trivial_out = (oc1 & oc2) != 4'b0000;
    resolve     = trivial_in || trivial_out || (steps == MAX_STEPS);
    sel_ep2     = (oc1 == 4'b0000);
    oc_t        = sel_ep2 ? oc2 : oc1;
    sel_x       = 1'b1;
    edge_v      = XMIN;
    if (oc_t[0]) begin
      sel_x  = 1'b1;
      edge_v = XMIN;
    end else if (oc_t[3]) begin
      sel_x  = 1'b0;
      edge_v = YMIN;
    end else if (oc_t[1]) begin
      sel_x  = 1'b1;
      edge_v = XMAX;
    end else if (oc_t[2]) begin
      sel_x  = 1'b0;
      edge_v = YMAX;
    end
    dx      = sx(x2) - sx(x1);
    dy      = sx(y2) - sx(y1);
    d_edge  = sel_x ? dx : dy;
    d_other = sel_x ? dy : dx;
    if (sel_x)
      coord = sel_ep2 ? x2 : x1;
    else
      coord = sel_ep2 ? y2 : y1;
    num     = d_other * (sx(edge_v) - sx(coord));
    num_mag = num[31] ? -num : num;
    den_mag = d_edge[31] ? -d_edge : d_edge;
  end

  // Restoring divide on magnitudes; sign applied afterwards gives truncation toward zero
  assign rem_sh   = {rem, quo[31]};
  assign rem_diff = rem_sh - {1'b0, dvs};
  assign rem_ge   = ~rem_diff[32];
  assign quot     = q_neg ? (~quo[15:0] + 16'd1) : quo[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = CODE;
      CODE: state_nx = resolve ? DONE : DIV;
      DIV:  if (div_cnt == 5'd31) state_nx = UPD;
      UPD:  state_nx = CODE;
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1       <= '0;
      y1       <= '0;
      x2       <= '0;
      y2       <= '0;
      id_q     <= 1'b0;
      reject_q <= 1'b0;
      steps    <= '0;
      div_cnt  <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      tgt_ep2  <= 1'b0;
      tgt_x    <= 1'b0;
      edge_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            {x1, y1, x2, y2} <= grant_id ? i_req1_line : i_req0_line;
            id_q     <= grant_id;
            reject_q <= 1'b0;
            steps    <= '0;
          end
        end
        CODE: begin
          if (resolve) begin
            reject_q <= ~trivial_in;
          end else begin
            rem     <= '0;
            quo     <= num_mag;
            dvs     <= den_mag;
            q_neg   <= num[31] ^ d_edge[31];
            div_cnt <= '0;
            tgt_ep2 <= sel_ep2;
            tgt_x   <= sel_x;
            edge_q  <= edge_v;
          end
        end
        DIV: begin
          rem     <= rem_ge ? rem_diff[31:0] : rem_sh[31:0];
          quo     <= {quo[30:0], rem_ge};
          div_cnt <= div_cnt + 5'd1;
        end
        UPD: begin
          steps <= steps + 4'd1;
          case ({tgt_ep2, tgt_x})
            2'b01: begin x1 <= edge_q; y1 <= y1 + quot; end
            2'b00: begin y1 <= edge_q; x1 <= x1 + quot; end
            2'b11: begin x2 <= edge_q; y2 <= y2 + quot; end
            default: begin y2 <= edge_q; x2 <= x2 + quot; end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_valid  = (state == DONE);
  assign o_busy   = (state != IDLE);
  assign o_line   = {x1, y1, x2, y2};
  assign o_reject = reject_q;
  assign o_id     = id_q;

endmodule
